// File: rtl/md_pkg.sv
// Shared op codes, widths and default latencies for the multiply/divide stage.
// The divider is compiled in only when MD_DIV_EN is defined.
package md_pkg;

    localparam int MD_OP_W   = 4;
    localparam int MD_DATA_W = 32;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    localparam logic [MD_OP_W-1:0] MD_NONE  = 4'd0;
    localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
    localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
    localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
    localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
    localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd5;
    localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd6;
    localparam logic [MD_OP_W-1:0] MD_MFHI  = 4'd7;
    localparam logic [MD_OP_W-1:0] MD_MFLO  = 4'd8;

endpackage

// File: rtl/md_div_core.sv
// Combinational 32-bit signed/unsigned divider: truncating quotient, remainder
// takes the dividend's sign, flags divide-by-zero and pins INT_MIN / -1.
module md_div_core
    import md_pkg::*;
(
    input  logic [MD_DATA_W-1:0] dividend,
    input  logic [MD_DATA_W-1:0] divisor,
    input  logic                 is_signed,
    output logic [MD_DATA_W-1:0] quotient,
    output logic [MD_DATA_W-1:0] remainder,
    output logic                 div_by_zero
);

    logic                 neg_a;
    logic                 neg_b;
    logic [MD_DATA_W-1:0] mag_a;
    logic [MD_DATA_W-1:0] mag_b;
    logic [MD_DATA_W-1:0] safe_b;
    logic [MD_DATA_W-1:0] q_mag;
    logic [MD_DATA_W-1:0] r_mag;

    always_comb begin
        neg_a       = is_signed & dividend[MD_DATA_W-1];
        neg_b       = is_signed & divisor[MD_DATA_W-1];
        mag_a       = neg_a ? ('0 - dividend) : dividend;
        mag_b       = neg_b ? ('0 - divisor) : divisor;
        div_by_zero = (divisor == '0);
        // Substitute 1 so the divide is always defined; result is discarded upstream.
        safe_b      = div_by_zero ? MD_DATA_W'(1) : mag_b;
        q_mag       = mag_a / safe_b;
        r_mag       = mag_a % safe_b;
        quotient    = (neg_a ^ neg_b) ? ('0 - q_mag) : q_mag;
        remainder   = neg_a ? ('0 - r_mag) : r_mag;
        if (is_signed && (dividend == 32'h8000_0000) && (divisor == '1)) begin
            quotient  = 32'h8000_0000;
            remainder = '0;
        end
    end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide control with architectural HI/LO, busy countdown and D-stage stall.
// Define MD_DIV_EN to build the DIV/DIVU path; otherwise those ops act as NONE.
module md_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [MD_OP_W-1:0]   md_op,
    input  logic [MD_DATA_W-1:0] rs_data,
    input  logic [MD_DATA_W-1:0] rt_data,
    input  logic                 md_in_d,
    output logic                 busy,
    output logic                 stall_req,
    output logic [MD_DATA_W-1:0] md_out,
    output logic [MD_DATA_W-1:0] hi,
    output logic [MD_DATA_W-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [MD_DATA_W-1:0]   hi_q, hi_d;
    logic [MD_DATA_W-1:0]   lo_q, lo_d;
    logic [2*MD_DATA_W-1:0] pend_q, pend_d;
    logic                   pend_wr_q, pend_wr_d;

    logic                   is_mul;
    logic                   is_div;
    logic                   issue;
    logic                   mul_signed;
    logic [2*MD_DATA_W-1:0] mul_a;
    logic [2*MD_DATA_W-1:0] mul_b;
    logic [2*MD_DATA_W-1:0] product;
    logic [MD_DATA_W-1:0]   div_q;
    logic [MD_DATA_W-1:0]   div_r;
    logic                   div_zero;

`ifdef MD_DIV_EN
    assign is_div = (md_op == MD_DIV) || (md_op == MD_DIVU);

    md_div_core u_div (
        .dividend    (rs_data),
        .divisor     (rt_data),
        .is_signed   (md_op == MD_DIV),
        .quotient    (div_q),
        .remainder   (div_r),
        .div_by_zero (div_zero)
    );
`else
    assign is_div   = 1'b0;
    assign div_q    = '0;
    assign div_r    = '0;
    assign div_zero = 1'b0;
`endif

    always_comb begin
        is_mul     = (md_op == MD_MULT) || (md_op == MD_MULTU);
        mul_signed = (md_op == MD_MULT);
        // Sign/zero-extend to 64 bits; the truncated 64x64 product is the exact 32x32 result.
        mul_a      = {{MD_DATA_W{mul_signed & rs_data[MD_DATA_W-1]}}, rs_data};
        mul_b      = {{MD_DATA_W{mul_signed & rt_data[MD_DATA_W-1]}}, rt_data};
        product    = mul_a * mul_b;

        busy       = (cnt_q != '0);
        issue      = start & ~busy & (is_mul | is_div);
        stall_req  = md_in_d & (busy | (start & (is_mul | is_div)));

        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        pend_d     = pend_q;
        pend_wr_d  = pend_wr_q;

        if (issue) begin
            cnt_d     = is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            pend_d    = is_mul ? product : {div_r, div_q};
            pend_wr_d = is_mul | ~div_zero;
        end else if (busy) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1) && pend_wr_q) begin
                hi_d = pend_q[2*MD_DATA_W-1:MD_DATA_W];
                lo_d = pend_q[MD_DATA_W-1:0];
            end
        end else if (start && md_op == MD_MTHI) begin
            hi_d = rs_data;
        end else if (start && md_op == MD_MTLO) begin
            lo_d = rs_data;
        end

        hi = hi_q;
        lo = lo_q;
        if (md_op == MD_MFHI) begin
            md_out = hi_q;
        end else if (md_op == MD_MFLO) begin
            md_out = lo_q;
        end else begin
            md_out = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_q    <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_q    <= pend_d;
            pend_wr_q <= pend_wr_d;
        end
    end

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl: expected busy length and HI/LO are queued at issue
// and popped when busy falls; DIV expectations depend on MD_DIV_EN.
module tb_md_ctrl;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        md_in_d;
    logic        busy;
    logic        stall_req;
    logic [31:0] md_out;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        string       tag;
        int          n;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .md_op     (md_op),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .md_in_d   (md_in_d),
        .busy      (busy),
        .stall_req (stall_req),
        .md_out    (md_out),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic exp_stall, input string tag);
        start   = 1'b1;
        md_op   = op;
        rs_data = a;
        rt_data = b;
        #1;
        check({tag, "_stall_issue"}, stall_req, exp_stall);
        step();
        start = 1'b0;
        md_op = MD_NONE;
    endtask

    // Counts busy cycles; optionally drives a stray start at busy cycle 2.
    task automatic run_busy(input logic inj, input logic [3:0] inj_op, input logic [31:0] inj_rs,
                            output int n, output logic stall_ok);
        n = 0;
        stall_ok = 1'b1;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (stall_req !== md_in_d) stall_ok = 1'b0;
            if (inj && n == 2) begin
                start   = 1'b1;
                md_op   = inj_op;
                rs_data = inj_rs;
                rt_data = 32'h3;
            end
            step();
            start = 1'b0;
            md_op = MD_NONE;
        end
    endtask

    task automatic complete(input logic inj, input logic [3:0] inj_op, input logic [31:0] inj_rs);
        int   n;
        logic ok;
        exp_t e;
        run_busy(inj, inj_op, inj_rs, n, ok);
        e = sb.pop_front();
        check({e.tag, "_busy_cycles"}, n, e.n);
        check({e.tag, "_stall_busy"}, ok, 1'b1);
        check({e.tag, "_stall_after"}, stall_req, 1'b0);
        check({e.tag, "_hi"}, hi, e.hi);
        check({e.tag, "_lo"}, lo, e.lo);
        exp_hi = e.hi;
        exp_lo = e.lo;
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        md_op   = MD_NONE;
        rs_data = '0;
        rt_data = '0;
        md_in_d = 1'b0;
        step();
        step();
        check("rst_busy", busy, 1'b0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_stall", stall_req, 1'b0);
        check("rst_md_out", md_out, 32'h0);
        reset = 1'b0;
        step();

        // MULT signed, stray MULT at busy cycle 2 must be ignored
        md_in_d = 1'b1;
        sb.push_back('{"mult", 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
        issue(MD_MULT, 32'hFFFF_FFFF, 32'h2, 1'b1, "mult");
        complete(1'b1, MD_MULT, 32'h7777_7777);

        // MULTU issued in the first idle cycle; MTLO during busy must be ignored
        md_in_d = 1'b0;
        sb.push_back('{"multu", 5, 32'h0000_0001, 32'hFFFF_FFFE});
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'h2, 1'b0, "multu");
        complete(1'b1, MD_MTLO, 32'hDEAD_BEEF);

        // MTHI / MTLO with MFHI / MFLO read-back
        start = 1'b1; md_op = MD_MTHI; rs_data = 32'h1234_5678;
        step();
        start = 1'b0; md_op = MD_MFHI;
        #1;
        check("mthi_busy", busy, 1'b0);
        check("mfhi_out", md_out, 32'h1234_5678);
        start = 1'b1; md_op = MD_MTLO; rs_data = 32'hCAFE_F00D;
        step();
        start = 1'b0; md_op = MD_MFLO;
        #1;
        check("mflo_out", md_out, 32'hCAFE_F00D);
        check("mthi_hold", hi, 32'h1234_5678);
        md_op = MD_NONE;
        #1;
        check("none_out", md_out, 32'h0);
        exp_hi = 32'h1234_5678;
        exp_lo = 32'hCAFE_F00D;

`ifdef MD_DIV_EN
        md_in_d = 1'b1;
        sb.push_back('{"div_neg", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
        issue(MD_DIV, 32'hFFFF_FFF9, 32'h2, 1'b1, "div_neg");
        complete(1'b0, MD_NONE, '0);

        sb.push_back('{"divu_zero", 10, exp_hi, exp_lo});
        issue(MD_DIVU, 32'h7, 32'h0, 1'b1, "divu_zero");
        complete(1'b0, MD_NONE, '0);

        sb.push_back('{"div_ovf", 10, 32'h0, 32'h8000_0000});
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_ovf");
        complete(1'b0, MD_NONE, '0);

        issue(MD_DIV, 32'd100, 32'd7, 1'b1, "div_abort");
`else
        md_in_d = 1'b1;
        issue(MD_DIV, 32'hFFFF_FFF9, 32'h2, 1'b0, "div_off");
        check("div_off_busy", busy, 1'b0);
        check("div_off_stall", stall_req, 1'b0);
        check("div_off_hi", hi, exp_hi);
        check("div_off_lo", lo, exp_lo);

        issue(MD_MULT, 32'd100, 32'd7, 1'b1, "mult_abort");
`endif
        // Abort at busy cycle 3
        step();
        step();
        check("abort_busy_pre", busy, 1'b1);
        reset = 1'b1;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 15; i++) step();
        check("abort_late_hi", hi, 32'h0);
        check("abort_late_lo", lo, 32'h0);
        check("abort_late_busy", busy, 1'b0);
        check("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
